// File: rtl/vga_fill_if.sv
// Register-bus and SDRAM write-port signals of the rectangle fill engine.
// The master modport is the engine side; slave is the CPU/arbiter side.
interface vga_fill_if #(
    parameter int unsigned ADDR_W = 26
);
    logic              hwregs_write;
    logic [15:0]       hwregs_addr;
    logic [31:0]       hwregs_wdata;
    logic              sdram_request;
    logic              sdram_ready;
    logic [ADDR_W-1:0] sdram_address;
    logic [31:0]       sdram_wdata;
    logic [3:0]        sdram_wmask;
    logic              busy;
    logic              done;

    modport master (
        input  hwregs_write, hwregs_addr, hwregs_wdata, sdram_ready,
        output sdram_request, sdram_address, sdram_wdata, sdram_wmask, busy, done
    );

    modport slave (
        output hwregs_write, hwregs_addr, hwregs_wdata, sdram_ready,
        input  sdram_request, sdram_address, sdram_wdata, sdram_wmask, busy, done
    );
endinterface

// File: rtl/vga_fill_engine.sv
// Rectangle fill engine: writes a solid palette index into the framebuffer
// using masked single-word SDRAM writes, one row of WIDTH bytes per STRIDE.
module vga_fill_engine #(
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned DIM_W  = 10
) (
    input  logic       clock,
    input  logic       reset,
    vga_fill_if.master bus
);
    localparam int unsigned STRIDE_W = 16;
    localparam int unsigned COLOR_W  = 8;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   dest_q;
    logic [DIM_W-1:0]    width_q, height_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [COLOR_W-1:0]  color_q;

    logic [ADDR_W-1:0]   row_start_q, row_start_d, cur_q, cur_d;
    logic [DIM_W-1:0]    rem_q, rem_d, rows_q, rows_d, lwidth_q, lwidth_d;
    logic [STRIDE_W-1:0] lstride_q, lstride_d;
    logic                req_q, req_d, busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          mask_q, mask_d;

    logic                reg_sel_c, start_c, load_c;
    logic [2:0]          n_c;
    logic                unused_wdata_c;

    // Bytes covered by the current word: min(4 - off, rem).
    function automatic logic [2:0] word_len(input logic [1:0] off, input logic [DIM_W-1:0] rem);
        logic [2:0] span;
        span = 3'd4 - {1'b0, off};
        if (DIM_W'(span) < rem) return span;
        return rem[2:0];
    endfunction

    function automatic logic [3:0] word_mask(input logic [1:0] off, input logic [2:0] n);
        logic [7:0] m;
        m = 8'((8'd1 << n) - 8'd1) << off;
        return m[3:0];
    endfunction

    assign reg_sel_c      = bus.hwregs_write && (bus.hwregs_addr[15:8] == 8'h02) && !busy_q;
    assign start_c        = reg_sel_c && (bus.hwregs_addr[7:0] == 8'h14);
    assign unused_wdata_c = ^bus.hwregs_wdata[31:ADDR_W];

    // Configuration registers; frozen while a fill is running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dest_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            stride_q <= '0;
            color_q  <= '0;
        end else if (reg_sel_c) begin
            case (bus.hwregs_addr[7:0])
                8'h00:   dest_q   <= bus.hwregs_wdata[ADDR_W-1:0];
                8'h04:   width_q  <= bus.hwregs_wdata[DIM_W-1:0];
                8'h08:   height_q <= bus.hwregs_wdata[DIM_W-1:0];
                8'h0C:   stride_q <= bus.hwregs_wdata[STRIDE_W-1:0];
                8'h10:   color_q  <= bus.hwregs_wdata[COLOR_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_start_q <= '0;
            cur_q       <= '0;
            rem_q       <= '0;
            rows_q      <= '0;
            lwidth_q    <= '0;
            lstride_q   <= '0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_start_q <= row_start_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            rows_q      <= rows_d;
            lwidth_q    <= lwidth_d;
            lstride_q   <= lstride_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_start_d = row_start_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        rows_d      = rows_q;
        lwidth_d    = lwidth_q;
        lstride_d   = lstride_q;
        req_d       = req_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        load_c      = 1'b0;
        n_c         = word_len(cur_q[1:0], rem_q);

        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    row_start_d = dest_q;
                    cur_d       = dest_q;
                    rem_d       = width_q;
                    rows_d      = height_q;
                    lwidth_d    = width_q;
                    lstride_d   = stride_q;
                    wdata_d     = {4{color_q}};
                    busy_d      = 1'b1;
                    if (width_q == '0 || height_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WRITE;
                        req_d   = 1'b1;
                        load_c  = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (req_q && bus.sdram_ready) begin
                    if (rem_q > DIM_W'(n_c)) begin
                        cur_d  = cur_q + ADDR_W'(n_c);
                        rem_d  = rem_q - DIM_W'(n_c);
                        load_c = 1'b1;
                    end else if (rows_q == DIM_W'(1)) begin
                        state_d = S_DONE;
                        req_d   = 1'b0;
                    end else begin
                        rows_d      = rows_q - DIM_W'(1);
                        row_start_d = row_start_q + ADDR_W'(lstride_q);
                        cur_d       = row_start_d;
                        rem_d       = lwidth_q;
                        load_c      = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Next word is registered so it is presented the cycle after a transfer.
        if (load_c) begin
            addr_d = {cur_d[ADDR_W-1:2], 2'b00};
            mask_d = word_mask(cur_d[1:0], word_len(cur_d[1:0], rem_d));
        end
    end

    assign bus.sdram_request = req_q;
    assign bus.sdram_address = addr_q;
    assign bus.sdram_wdata   = wdata_q;
    assign bus.sdram_wmask   = mask_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_vga_fill_engine.sv
// Scoreboard bench for vga_fill_engine: a pixel-level model predicts the
// word writes and done pulses, and a negedge monitor checks what the DUT emits.
module tb_vga_fill_engine;
    localparam int unsigned ADDR_W = 26;

    typedef struct {
        logic [25:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } xfer_t;

    logic  clock = 1'b0;
    logic  reset;
    xfer_t exp_q[$];
    int    exp_done   = 0;
    int    checks     = 0;
    int    errors     = 0;
    bit    ignore_sb  = 1'b0;
    int    ready_mode = 0;

    always #5 clock = ~clock;

    vga_fill_if #(.ADDR_W(ADDR_W)) bus ();

    vga_fill_engine #(.ADDR_W(ADDR_W), .DIM_W(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Walk every pixel of the rectangle; consecutive bytes of a row sharing a word form one write.
    task automatic model_fill(input logic [25:0] dest, input int w, input int h,
                              input logic [15:0] stride, input logic [7:0] color);
        logic [25:0] row, a, word;
        logic [3:0]  m;
        bit          open;
        word = '0;
        m    = '0;
        if (w != 0 && h != 0) begin
            row = dest;
            for (int r = 0; r < h; r++) begin
                open = 1'b0;
                for (int c = 0; c < w; c++) begin
                    a = row + 26'(c);
                    if (open && {a[25:2], 2'b00} != word) begin
                        exp_q.push_back('{word, m, {4{color}}});
                        open = 1'b0;
                    end
                    if (!open) begin
                        word = {a[25:2], 2'b00};
                        m    = '0;
                        open = 1'b1;
                    end
                    m[a[1:0]] = 1'b1;
                end
                exp_q.push_back('{word, m, {4{color}}});
                row = row + 26'(stride);
            end
        end
        exp_done++;
    endtask

    task automatic reg_write(input logic [7:0] off, input logic [31:0] data);
        bus.hwregs_write = 1'b1;
        bus.hwregs_addr  = {8'h02, off};
        bus.hwregs_wdata = data;
        @(posedge clock); #1;
        bus.hwregs_write = 1'b0;
    endtask

    // Program and start; returns one cycle after the START write.
    task automatic run_fill(input bit set_dest, input logic [25:0] dest, input int w, input int h,
                            input logic [15:0] stride, input logic [7:0] color);
        if (set_dest) reg_write(8'h00, 32'(dest));
        reg_write(8'h04, 32'(w));
        reg_write(8'h08, 32'(h));
        reg_write(8'h0C, 32'(stride));
        reg_write(8'h10, 32'(color));
        model_fill(dest, w, h, stride, color);
        reg_write(8'h14, 32'h0);
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_request", 32'(bus.sdram_request), 32'((w != 0 && h != 0) ? 1 : 0));
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (exp_done != 0 && cyc < 5000) begin
            @(posedge clock); #1;
            cyc++;
        end
        checks++;
        if (exp_done != 0) begin
            errors++;
            $display("FAIL done_timeout actual=%0d pending required=0", exp_done);
            exp_done = 0;
            exp_q.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Arbiter ready: always, random, or held off.
    initial begin
        bus.sdram_ready = 1'b0;
        forever begin
            @(posedge clock); #1;
            case (ready_mode)
                0:       bus.sdram_ready = 1'b1;
                1:       bus.sdram_ready = 1'($urandom_range(0, 1));
                default: bus.sdram_ready = 1'b0;
            endcase
        end
    end

    // Monitor: transfers, hold-while-stalled and done pulses against the scoreboard.
    initial begin
        bit          prev_stall = 1'b0;
        bit          prev_done  = 1'b0;
        logic [25:0] p_addr;
        logic [3:0]  p_mask;
        logic [31:0] p_data;
        xfer_t       e;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (prev_stall && !ignore_sb) begin
                    check("hold_request", 32'(bus.sdram_request), 32'd1);
                    check("hold_addr", 32'(bus.sdram_address), 32'(p_addr));
                    check("hold_mask", 32'(bus.sdram_wmask), 32'(p_mask));
                    check("hold_wdata", bus.sdram_wdata, p_data);
                end
                if (bus.sdram_request && bus.sdram_ready && !ignore_sb) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_xfer actual_addr=%h required=none", bus.sdram_address);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_addr", 32'(bus.sdram_address), 32'(e.addr));
                        check("xfer_mask", 32'(bus.sdram_wmask), 32'(e.mask));
                        check("xfer_wdata", bus.sdram_wdata, e.data);
                    end
                end
                prev_stall = bus.sdram_request && !bus.sdram_ready;
                p_addr     = bus.sdram_address;
                p_mask     = bus.sdram_wmask;
                p_data     = bus.sdram_wdata;
                if (bus.done && !ignore_sb) begin
                    check("done_busy_low", 32'(bus.busy), 32'd0);
                    check("done_single_cycle", 32'(prev_done), 32'd0);
                    if (exp_done == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_done actual=1 required=0");
                    end else begin
                        check("done_xfers_left", 32'(exp_q.size()), 32'd0);
                        exp_done--;
                    end
                end
                prev_done = bus.done;
            end
        end
    end

    initial begin
        logic [25:0] rdest;
        int          rw, rh;
        reset            = 1'b1;
        bus.hwregs_write = 1'b0;
        bus.hwregs_addr  = '0;
        bus.hwregs_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_request", 32'(bus.sdram_request), 32'd0);
        check("rst_address", 32'(bus.sdram_address), 32'd0);
        check("rst_wdata", bus.sdram_wdata, 32'd0);
        check("rst_wmask", 32'(bus.sdram_wmask), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        ready_mode = 0;
        run_fill(1'b1, 26'h1000, 4, 1, 16'd0, 8'h5A);
        wait_done();
        run_fill(1'b1, 26'h1001, 6, 1, 16'd0, 8'h11);
        wait_done();
        run_fill(1'b1, 26'h2002, 1, 3, 16'd640, 8'h33);
        wait_done();

        // Arbiter stalls for 10 cycles with the request up.
        ready_mode = 2;
        run_fill(1'b1, 26'h1000, 4, 1, 16'd0, 8'h5A);
        repeat (10) @(posedge clock);
        #1;
        ready_mode = 0;
        wait_done();

        // Empty fill; a DEST write while busy must not land.
        run_fill(1'b1, 26'h3000, 0, 5, 16'd0, 8'h22);
        reg_write(8'h00, 32'h0ABCDE);
        wait_done();
        run_fill(1'b0, 26'h3000, 4, 1, 16'd0, 8'h44);
        wait_done();

        // Reset in the middle of a large fill, then a fresh fill from cleared registers.
        ignore_sb  = 1'b1;
        ready_mode = 1;
        reg_write(8'h00, 32'h0);
        reg_write(8'h04, 32'd640);
        reg_write(8'h08, 32'd480);
        reg_write(8'h0C, 32'd640);
        reg_write(8'h10, 32'h99);
        reg_write(8'h14, 32'h0);
        repeat (40) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_request", 32'(bus.sdram_request), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        exp_done   = 0;
        ignore_sb  = 1'b0;
        ready_mode = 0;
        @(posedge clock); #1;
        run_fill(1'b0, 26'h0, 4, 1, 16'd0, 8'h77);
        wait_done();

        // Randomized fills, some straddling the top of the address space.
        for (int i = 0; i < 12; i++) begin
            rdest      = (i % 4 == 3) ? 26'h3FFFFF0 + 26'($urandom_range(0, 15)) : 26'($urandom);
            rw         = $urandom_range(0, 12);
            rh         = $urandom_range(0, 3);
            ready_mode = $urandom_range(0, 1);
            run_fill(1'b1, rdest, rw, rh, 16'($urandom), 8'($urandom));
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
